led_scan_sequencer: RTL and testbench
=====================================

# led_scan_sequencer

Time-multiplexed column scan controller for the Conway LED array. It generates the enable and column-index inputs that the combinational LED array driver decodes into one-hot column drive and active-low row drive. It holds a double-buffered copy of the cell grid and accepts new generations through a valid/ready handshake. New frames swap in only at frame boundaries, so a displayed frame is never torn.

## Interface
Parameters:
- N, 5, grid side length; legal range 1..8.
- DWELL_CYCLES, 1000, clock cycles each column is driven (ena high); must be ≥ 1.
- BLANK_CYCLES, 16, clock cycles of ena low between columns (anti-ghosting); must be ≥ 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cells_in  input  N*N  next generation; bit r*N+c is row r, column c.
- cells_valid  input  1  cells_in holds a frame to be accepted.
- cells_ready  output  1  the pending buffer is empty and can accept a frame.
- ena  output  1  column decoder enable.
- x  output  $clog2(N)+1  current column index, 0..N-1.
- cells  output  N*N  display buffer, fed to the array driver.
- frame_start  output  1  single-cycle pulse on the first driven cycle of column 0.

## Operation
- Storage: `disp` is the display buffer and drives `cells`. `pend` is the pending buffer, with a `pend_full` flag.
- Two-state FSM:
  - BLANK: ena=0. The cycle counter counts 0..BLANK_CYCLES-1, then the FSM moves to DRIVE with the counter cleared.
  - DRIVE: ena=1. The counter counts 0..DWELL_CYCLES-1. On the last count the FSM returns to BLANK and x advances.
- x advance: x goes to x+1. From N-1 it wraps to 0. x changes only on the DRIVE→BLANK transition, so it is stable whenever ena=1.
- Handshake:
  - cells_ready = ~pend_full.
  - On cells_valid & cells_ready, cells_in is captured into pend and pend_full is set on the same edge.
  - cells_in is not sampled at any other time.
- Swap: at the DRIVE→BLANK edge where x wraps N-1→0, if pend_full, then disp←pend and pend_full is cleared.
  - Accept and swap cannot coincide, because accept requires pend_full=0 and swap requires pend_full=1.
- frame_start: asserted for exactly the first DRIVE cycle with x=0.
- Reset (asynchronous, takes effect without a clock edge):
  - FSM=BLANK, counter=0, x=0, ena=0.
  - disp=0, pend=0, pend_full=0, so cells_ready=1.
  - frame_start=0.
  - Reset mid-frame discards any pending frame.
- Elaboration: `$error` if N is outside 1..8, or if DWELL_CYCLES<1 or BLANK_CYCLES<1.

## Timing
- Column period = BLANK_CYCLES+DWELL_CYCLES. Frame period = N×(BLANK_CYCLES+DWELL_CYCLES).
- After reset deasserts, the first rising edge starts BLANK count 0. ena first rises after BLANK_CYCLES edges.
- cells_ready falls on the edge after the accept. It rises on the swap edge.
- Display latency from accept to visible in cells: at most one frame period plus one cycle. The new frame is visible on the first BLANK cycle of column 0.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- Macro: `LED_SCAN_BLANK_EN`.
- Defined: BLANK state is present, as described above.
- Undefined:
  - BLANK state is removed and BLANK_CYCLES is ignored.
  - ena=0 only while rst is asserted and goes to 1 on the first edge after reset.
  - x advances every DWELL_CYCLES cycles.
  - The swap occurs on the DWELL edge where x wraps N-1→0.
  - frame_start pulses on the first cycle with x=0.

## Test plan
All scenarios use N=5, DWELL_CYCLES=4, BLANK_CYCLES=2, with the macro defined unless stated.
- Reset: assert rst → ena=0, x=0, cells=0, cells_ready=1, frame_start=0.
- Free-run scan: release rst → ena pattern 0,0,1,1,1,1 repeats. x steps 0,1,2,3,4,0 every 6 cycles. frame_start pulses every 30 cycles at the first ena=1 with x=0.
- Frame load mid-frame: during x=2, present cells_in=25'h1555555 with valid high for 1 cycle.
  - cells_ready falls next cycle.
  - cells stays 0 until the x 4→0 edge, then becomes 25'h1555555 and cells_ready returns to 1.
- Backpressure: with pend full, hold valid high with 25'h0AAAAAA → no capture while ready=0. It is accepted on the first cycle after the swap and displayed one frame later.
- Async reset mid-DRIVE at x=3 with a frame pending → ena=0, x=0, cells=0, cells_ready=1 immediately, with no clock edge. The pending frame is never displayed.
- Macro undefined → ena=1 continuously after reset. x advances every 4 cycles, giving a frame period of 20 cycles.

Source files
------------

// File: rtl/led_scan_sequencer.sv
// led_scan_sequencer: double-buffered column scan controller for the LED array.
// Define LED_SCAN_BLANK_EN to insert an anti-ghosting blank gap between columns.
module led_scan_sequencer #(
  parameter int N            = 5,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*N-1:0]     cells_in,
  input  logic               cells_valid,
  output logic               cells_ready,
  output logic               ena,
  output logic [$clog2(N):0] x,
  output logic [N*N-1:0]     cells,
  output logic               frame_start
);

  localparam int XW   = $clog2(N) + 1;
  localparam int CMAX = (DWELL_CYCLES > BLANK_CYCLES) ?
                        DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX) + 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [XW-1:0] X_LAST     = XW'(N - 1);

  if ((N < 1) || (N > 8) ||
      (DWELL_CYCLES < 1) || (BLANK_CYCLES < 1)) begin : g_param_err
    $error("led_scan_sequencer: illegal N/DWELL_CYCLES/BLANK_CYCLES");
  end

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [XW-1:0]  x_q;
  logic [N*N-1:0] disp_q, pend_q;
  logic           pend_full_q;
  logic           col_end, fs_d;
  logic           wrap, accept, swap;

`ifdef LED_SCAN_BLANK_EN
  typedef enum logic {BLANK, DRIVE} state_t;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  state_t state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= BLANK;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    col_end = 1'b0;
    fs_d    = 1'b0;
    unique case (state_q)
      BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
          fs_d    = (x_q == '0);
        end
      end
      DRIVE: begin
        if (cnt_q == DWELL_LAST) begin
          state_d = BLANK;
          cnt_d   = '0;
          col_end = 1'b1;
        end
      end
    endcase
  end

  assign ena = (state_q == DRIVE);
`else
  // run_q marks the first edge out of reset; the scan is always driving after it
  logic run_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_q <= 1'b0;
    else     run_q <= 1'b1;
  end

  always_comb begin
    cnt_d   = cnt_q + CW'(1);
    col_end = 1'b0;
    fs_d    = ~run_q;
    if (!run_q) begin
      cnt_d = '0;
    end else if (cnt_q == DWELL_LAST) begin
      cnt_d   = '0;
      col_end = 1'b1;
      fs_d    = (x_q == X_LAST);
    end
  end

  assign ena = run_q;
`endif

  assign wrap   = col_end && (x_q == X_LAST);
  assign accept = cells_valid && !pend_full_q;
  // accept needs an empty buffer, swap a full one, so they never coincide
  assign swap   = wrap && pend_full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      x_q         <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      frame_start <= fs_d;
      if (col_end) x_q <= wrap ? '0 : x_q + XW'(1);
      if (accept) begin
        pend_q      <= cells_in;
        pend_full_q <= 1'b1;
      end else if (swap) begin
        disp_q      <= pend_q;
        pend_full_q <= 1'b0;
      end
    end
  end

  assign x           = x_q;
  assign cells       = disp_q;
  assign cells_ready = ~pend_full_q;

endmodule

// File: tb/tb_led_scan_sequencer.sv
// tb_led_scan_sequencer: scoreboard bench for led_scan_sequencer.
// Expected outputs come from a closed-form scan-timing model plus buffer model.
module tb_led_scan_sequencer;

  localparam int N  = 5;
  localparam int DW = 4;
  localparam int BL = 2;
  localparam int NN = N * N;
`ifdef LED_SCAN_BLANK_EN
  localparam int CP = BL + DW;
`else
  localparam int CP = DW;
`endif
  localparam int FP = N * CP;

  typedef struct packed {
    logic          ena;
    logic [3:0]    x;
    logic          fs;
    logic          rdy;
    logic [NN-1:0] cells;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NN-1:0] cells_in = '0;
  logic          cells_valid = 1'b0;
  logic          cells_ready;
  logic          ena;
  logic [3:0]    x;
  logic [NN-1:0] cells;
  logic          frame_start;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_bad = 0;
  int            t = 0;
  bit            m_pf = 1'b0;
  logic [NN-1:0] m_pend = '0;
  logic [NN-1:0] m_disp = '0;
  bit            acc_seen = 1'b0;

  always #5 clk = ~clk;

  led_scan_sequencer #(
    .N(N), .DWELL_CYCLES(DW), .BLANK_CYCLES(BL)
  ) dut (
    .clk(clk), .rst(rst),
    .cells_in(cells_in), .cells_valid(cells_valid),
    .cells_ready(cells_ready), .ena(ena), .x(x),
    .cells(cells), .frame_start(frame_start)
  );

`ifdef LED_SCAN_BLANK_EN
  function automatic logic f_ena(int tt);
    return (tt % CP) >= BL;
  endfunction
  function automatic int f_x(int tt);
    return (tt / CP) % N;
  endfunction
  function automatic logic f_fs(int tt);
    return (tt % FP) == BL;
  endfunction
  function automatic logic f_swap(int tt);
    return (tt > 0) && (tt % FP == 0);
  endfunction
`else
  function automatic logic f_ena(int tt);
    return tt >= 1;
  endfunction
  function automatic int f_x(int tt);
    return (tt >= 1) ? ((tt - 1) / DW) % N : 0;
  endfunction
  function automatic logic f_fs(int tt);
    return (tt >= 1) && ((tt - 1) % FP == 0);
  endfunction
  function automatic logic f_swap(int tt);
    return (tt > 1) && ((tt - 1) % FP == 0);
  endfunction
`endif

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got %h want %h", tag, t, got, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    acc_seen = 1'b0;
    if (f_swap(t + 1) && m_pf) begin
      m_disp = m_pend;
      m_pf   = 1'b0;
    end else if (cells_valid && !m_pf) begin
      m_pend   = cells_in;
      m_pf     = 1'b1;
      acc_seen = 1'b1;
    end
    t++;
    e.ena   = f_ena(t);
    e.x     = 4'(f_x(t));
    e.fs    = f_fs(t);
    e.rdy   = !m_pf;
    e.cells = m_disp;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("ena", 32'(ena), 32'(e.ena));
    chk("x", 32'(x), 32'(e.x));
    chk("frame_start", 32'(frame_start), 32'(e.fs));
    chk("cells_ready", 32'(cells_ready), 32'(e.rdy));
    chk("cells", 32'(cells), 32'(e.cells));
  endtask

  // async reset checked before any clock edge, then released mid-cycle
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ena", 32'(ena), 32'd0);
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_cells", 32'(cells), 32'd0);
    chk("rst_ready", 32'(cells_ready), 32'd1);
    chk("rst_fs", 32'(frame_start), 32'd0);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    t      = 0;
    m_pf   = 1'b0;
    m_pend = '0;
    m_disp = '0;
    sb.delete();
  endtask

  task automatic run_until_x(int xv, bit need_ena);
    int k = 0;
    while (k < 4 * FP && !(x == 4'(xv) && (ena || !need_ena))) begin
      step();
      k++;
    end
    chk("reach_x", 32'(x), 32'(xv));
  endtask

  initial begin
    #2;
    do_reset();
    repeat (2 * FP + 2) step();

    run_until_x(2, 1'b0);
    cells_in    = 25'h1555555;
    cells_valid = 1'b1;
    step();
    cells_valid = 1'b0;
    cells_in    = '0;
    chk("load_rdy_fall", 32'(cells_ready), 32'd0);
    repeat (FP + 5) step();
    chk("load_disp", 32'(cells), 32'h1555555);
    chk("load_rdy_back", 32'(cells_ready), 32'd1);

    cells_in    = 25'h0123456;
    cells_valid = 1'b1;
    step();
    cells_in = 25'h0AAAAAA;
    for (int k = 0; k < 2 * FP; k++) begin
      step();
      if (acc_seen) break;
    end
    cells_valid = 1'b0;
    cells_in    = '0;
    chk("bp_first", 32'(cells), 32'h0123456);
    chk("bp_rdy", 32'(cells_ready), 32'd0);
    repeat (FP + 2) step();
    chk("bp_disp", 32'(cells), 32'h0AAAAAA);

    run_until_x(0, 1'b1);
    cells_in    = 25'h1F0F0F0;
    cells_valid = 1'b1;
    step();
    cells_valid = 1'b0;
    cells_in    = '0;
    run_until_x(3, 1'b1);
    chk("mid_ena", 32'(ena), 32'd1);
    chk("mid_pend", 32'(cells_ready), 32'd0);
    #2;
    do_reset();
    repeat (2 * FP + 3) step();
    chk("no_stale", 32'(cells), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
